// File: rtl/wb_snoop_responder_pkg.sv
// Shared snoop-bus encodings: snoop types, poll responses and the one-hot responder FSM states.
// Also used by the arbiter side so both ends agree on the 2-bit codes.
package wb_snoop_responder_pkg;

    typedef enum logic [1:0] {
        SNOOP_TYPE_IDLE     = 2'b00,
        SNOOP_TYPE_READ     = 2'b01,
        SNOOP_TYPE_WRITE    = 2'b10,
        SNOOP_TYPE_NOT_USED = 2'b11
    } snoop_type_e;

    typedef enum logic [1:0] {
        POLL_RESPONSE_NEGATIVE  = 2'b00,
        POLL_RESPONSE_UNDEFINED = 2'b10,
        POLL_RESPONSE_POSITIVE  = 2'b11
    } poll_response_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_REQ    = 4'b0010,
        ST_LOOKUP = 4'b0100,
        ST_RESP   = 4'b1000
    } snoop_state_e;

    // READ and WRITE snoops need a tag lookup; NOT_USED is answered without one.
    function automatic logic needs_lookup(input logic [1:0] snoop_type);
        return (snoop_type == SNOOP_TYPE_READ) || (snoop_type == SNOOP_TYPE_WRITE);
    endfunction

endpackage

// File: rtl/wb_snoop_responder_if.sv
// Snoop bus from the arbiter plus the shared cache snoop port, bundled for one responder.
// slave = responder view, master = arbiter/cache view.
interface wb_snoop_responder_if #(
    parameter int aw    = 32,
    parameter int dw    = 32,
    parameter int IDX_W = 8,
    parameter int OFS_W = 2
);
    localparam int TAG_W = aw - IDX_W - OFS_W;

    logic [aw-1:0]    snoop_adr_i;
    logic [1:0]       snoop_type_i;
    logic [1:0]       snoop_response_o;
    logic [dw-1:0]    snooped_dat_o;
    logic             tag_req_o;
    logic             tag_gnt_i;
    logic [IDX_W-1:0] tag_idx_o;
    logic [TAG_W-1:0] tag_i;
    logic             valid_i;
    logic [dw-1:0]    dat_i;
    logic             inv_o;
    logic [IDX_W-1:0] inv_idx_o;

    modport slave (
        input  snoop_adr_i, snoop_type_i, tag_gnt_i, tag_i, valid_i, dat_i,
        output snoop_response_o, snooped_dat_o, tag_req_o, tag_idx_o, inv_o, inv_idx_o
    );

    modport master (
        output snoop_adr_i, snoop_type_i, tag_gnt_i, tag_i, valid_i, dat_i,
        input  snoop_response_o, snooped_dat_o, tag_req_o, tag_idx_o, inv_o, inv_idx_o
    );

endinterface

// File: rtl/wb_snoop_responder_tag_match.sv
// Combinational hit detect: stored line valid and stored tag equal to the snooped tag.
// Zero latency, no flow control.
module wb_snoop_responder_tag_match #(
    parameter int TAG_W = 22
) (
    input  logic [TAG_W-1:0] stored_tag,
    input  logic             stored_valid,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit
);

    assign hit = stored_valid && (stored_tag == lookup_tag);

endmodule

// File: rtl/wb_snoop_responder.sv
// Per-core snoop responder: looks the snooped line up in L1 and answers READ with data, WRITE with invalidate.
// Response registered 3 cycles after the snoop is sampled, plus one per denied tag-port cycle; held until type returns to IDLE.
module wb_snoop_responder
    import wb_snoop_responder_pkg::*;
#(
    parameter int aw    = 32,
    parameter int dw    = 32,
    parameter int IDX_W = 8,
    parameter int OFS_W = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_snoop_responder_if.slave bus
);

    localparam int TAG_W = aw - IDX_W - OFS_W;

    snoop_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic             wr_q;
    logic [1:0]       resp_q;
    logic [dw-1:0]    dat_q;
    logic             hit;
    logic             abort;
    logic             tag_req;
    logic             inv;
    logic             unused_ofs;

    // Byte offset within the line never affects the lookup.
    assign unused_ofs = ^bus.snoop_adr_i[OFS_W-1:0];

    assign abort = (bus.snoop_type_i == SNOOP_TYPE_IDLE);

    wb_snoop_responder_tag_match #(.TAG_W(TAG_W)) u_tag_match (
        .stored_tag   (bus.tag_i),
        .stored_valid (bus.valid_i),
        .lookup_tag   (tag_q),
        .hit          (hit)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (needs_lookup(bus.snoop_type_i))                 state_d = ST_REQ;
                else if (bus.snoop_type_i == SNOOP_TYPE_NOT_USED)   state_d = ST_RESP;
            end
            ST_REQ: begin
                if (abort)              state_d = ST_IDLE;
                else if (bus.tag_gnt_i) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: state_d = abort ? ST_IDLE : ST_RESP;
            ST_RESP:   if (abort) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A withdrawn snoop drops the port request and suppresses the invalidate in the same cycle.
    always_comb begin
        tag_req = 1'b0;
        inv     = 1'b0;
        unique case (state_q)
            ST_REQ:    tag_req = !abort;
            ST_LOOKUP: inv     = wr_q && hit && !abort;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q  <= '0;
            tag_q  <= '0;
            wr_q   <= 1'b0;
            resp_q <= POLL_RESPONSE_UNDEFINED;
            dat_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (needs_lookup(bus.snoop_type_i)) begin
                        idx_q <= bus.snoop_adr_i[OFS_W +: IDX_W];
                        tag_q <= bus.snoop_adr_i[aw-1 -: TAG_W];
                        wr_q  <= (bus.snoop_type_i == SNOOP_TYPE_WRITE);
                    end else if (bus.snoop_type_i == SNOOP_TYPE_NOT_USED) begin
                        resp_q <= POLL_RESPONSE_NEGATIVE;
                    end
                end
                ST_LOOKUP: begin
                    if (!abort) begin
                        resp_q <= hit ? POLL_RESPONSE_POSITIVE : POLL_RESPONSE_NEGATIVE;
                        dat_q  <= (hit && !wr_q) ? bus.dat_i : '0;
                    end
                end
                ST_RESP: begin
                    if (abort) begin
                        resp_q <= POLL_RESPONSE_UNDEFINED;
                        dat_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.snoop_response_o = resp_q;
    assign bus.snooped_dat_o    = dat_q;
    assign bus.tag_req_o        = tag_req;
    assign bus.tag_idx_o        = idx_q;
    assign bus.inv_o            = inv;
    assign bus.inv_idx_o        = idx_q;

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Bench for wb_snoop_responder: directed snoop scenarios plus random snoops against a line-level cache reference.
module tb_wb_snoop_responder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int OW = 2;
    localparam int TW = AW - IW - OW;

    localparam logic [1:0] T_IDLE  = 2'b00;
    localparam logic [1:0] T_READ  = 2'b01;
    localparam logic [1:0] T_WRITE = 2'b10;
    localparam logic [1:0] T_NU    = 2'b11;
    localparam logic [1:0] R_UND   = 2'b10;
    localparam logic [1:0] R_POS   = 2'b11;
    localparam logic [1:0] R_NEG   = 2'b00;
    localparam logic [31:0] ADR_A  = 32'hFFFFC048;
    localparam logic [7:0]  IDX_A  = 8'h12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_snoop_responder_if #(.aw(AW), .dw(DW), .IDX_W(IW), .OFS_W(OW)) bus ();

    wb_snoop_responder #(.aw(AW), .dw(DW), .IDX_W(IW), .OFS_W(OW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    // Cache RAM as seen by the responder (updated only by inv_o) and the reference view of the same lines.
    logic          ram_valid [256];
    logic [TW-1:0] ram_tag   [256];
    logic [DW-1:0] ram_dat   [256];
    logic          ref_valid [256];
    logic [TW-1:0] ref_tag   [256];
    logic [DW-1:0] ref_dat   [256];

    int checks = 0;
    int errors = 0;
    int inv_pulses = 0;
    int req_cycles = 0;
    int denied = 0;
    logic [IW-1:0] last_inv_idx = '0;

    function automatic logic [7:0] idx_of(input logic [31:0] a);
        return a[9:2];
    endfunction

    function automatic logic [TW-1:0] tag_of(input logic [31:0] a);
        return a[31:10];
    endfunction

    function automatic logic ref_hit(input logic [31:0] a);
        return ref_valid[idx_of(a)] && (ref_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic [1:0] exp_resp(input logic [1:0] typ, input logic [31:0] a);
        if (typ == T_NU) return R_NEG;
        return ref_hit(a) ? R_POS : R_NEG;
    endfunction

    function automatic logic [31:0] exp_dat(input logic [1:0] typ, input logic [31:0] a);
        return (typ == T_READ && ref_hit(a)) ? ref_dat[idx_of(a)] : 32'h0;
    endfunction

    task automatic set_line(input logic [7:0] i, input logic v, input logic [TW-1:0] t, input logic [31:0] d);
        ram_valid[i] = v; ram_tag[i] = t; ram_dat[i] = d;
        ref_valid[i] = v; ref_tag[i] = t; ref_dat[i] = d;
    endtask

    // One clock: sample the snoop-port requests mid-cycle, then play the cache RAM after the edge.
    task automatic tick();
        logic rd, iv;
        logic [IW-1:0] rd_idx, iv_idx;
        logic [31:0] r0, r1;
        @(negedge clk);
        rd     = (bus.tag_req_o === 1'b1) && (bus.tag_gnt_i === 1'b1);
        iv     = (bus.inv_o === 1'b1);
        rd_idx = bus.tag_idx_o;
        iv_idx = bus.inv_idx_o;
        if (bus.tag_req_o === 1'b1) begin
            req_cycles++;
            if (bus.tag_gnt_i !== 1'b1) denied++;
        end
        if (iv) begin
            inv_pulses++;
            last_inv_idx = iv_idx;
        end
        @(posedge clk);
        #1;
        if (iv && !rst) ram_valid[iv_idx] = 1'b0;
        if (rd && !rst) begin
            bus.tag_i   = ram_tag[rd_idx];
            bus.valid_i = ram_valid[rd_idx];
            bus.dat_i   = ram_dat[rd_idx];
        end else begin
            r0 = $urandom;
            r1 = $urandom;
            bus.tag_i   = r0[TW-1:0];
            bus.valid_i = r1[0];
            bus.dat_i   = r1;
        end
        #1;
    endtask

    // Issue a snoop, grant the port after 'deny' refused request cycles, stop when a response appears.
    task automatic do_snoop(input logic [1:0] typ, input logic [31:0] a, input int deny,
                            output logic [1:0] resp, output logic [31:0] dat, output int lat,
                            output int inv_n, output int req_n, output bit idx_bad);
        int inv0, req0;
        inv0 = inv_pulses;
        req0 = req_cycles;
        denied = 0;
        idx_bad = 1'b0;
        lat = 0;
        bus.snoop_type_i = typ;
        bus.snoop_adr_i  = a;
        bus.tag_gnt_i    = (deny == 0);
        do begin
            tick();
            lat++;
            if (bus.tag_req_o === 1'b1 && bus.tag_idx_o !== idx_of(a)) idx_bad = 1'b1;
            bus.tag_gnt_i = (denied >= deny);
        end while (bus.snoop_response_o === R_UND && lat < 40);
        resp  = bus.snoop_response_o;
        dat   = bus.snooped_dat_o;
        inv_n = inv_pulses - inv0;
        req_n = req_cycles - req0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (bus.snoop_response_o !== R_UND) begin errors++; $display("FAIL reset_resp: got %b want %b", bus.snoop_response_o, R_UND); end
        checks++; if (bus.snooped_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.snooped_dat_o); end
        checks++; if (bus.tag_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.tag_req_o); end
        checks++; if (bus.inv_o !== 1'b0) begin errors++; $display("FAIL reset_inv: got %b want 0", bus.inv_o); end
        checks++; if (bus.tag_idx_o !== 8'h0 || bus.inv_idx_o !== 8'h0) begin errors++; $display("FAIL reset_idx: got %h/%h want 0", bus.tag_idx_o, bus.inv_idx_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_hit();
        logic [1:0] r; logic [31:0] d; int lat, invn, reqn; bit bad;
        set_line(IDX_A, 1'b1, tag_of(ADR_A), 32'h40);
        do_snoop(T_READ, ADR_A, 0, r, d, lat, invn, reqn, bad);
        checks++; if (r !== R_POS) begin errors++; $display("FAIL rd_hit_resp: got %b want %b", r, R_POS); end
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL rd_hit_dat: got %h want 40", d); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_hit_latency: got %0d want 3", lat); end
        checks++; if (bad) begin errors++; $display("FAIL rd_hit_idx: got bad tag_idx want %h", IDX_A); end
        tick();
        tick();
        checks++; if (bus.snoop_response_o !== R_POS || bus.snooped_dat_o !== 32'h40) begin errors++; $display("FAIL rd_hit_hold: got %b/%h want 11/40", bus.snoop_response_o, bus.snooped_dat_o); end
        bus.snoop_type_i = T_IDLE;
        tick();
        checks++; if (bus.snoop_response_o !== R_UND || bus.snooped_dat_o !== 32'h0) begin errors++; $display("FAIL rd_hit_release: got %b/%h want 10/0", bus.snoop_response_o, bus.snooped_dat_o); end
    endtask

    task automatic test_read_miss();
        logic [1:0] r; logic [31:0] d; int lat, invn, reqn; bit bad;
        set_line(IDX_A, 1'b0, tag_of(ADR_A), 32'h40);
        do_snoop(T_READ, ADR_A, 0, r, d, lat, invn, reqn, bad);
        checks++; if (r !== R_NEG || d !== 32'h0) begin errors++; $display("FAIL rd_miss_invalid: got %b/%h want 00/0", r, d); end
        bus.snoop_type_i = T_IDLE;
        tick();
        set_line(IDX_A, 1'b1, tag_of(ADR_A) ^ 22'h1, 32'h40);
        do_snoop(T_READ, ADR_A, 0, r, d, lat, invn, reqn, bad);
        checks++; if (r !== R_NEG || d !== 32'h0) begin errors++; $display("FAIL rd_miss_tag: got %b/%h want 00/0", r, d); end
        bus.snoop_type_i = T_IDLE;
        tick();
    endtask

    task automatic test_write_hit();
        logic [1:0] r; logic [31:0] d; int lat, invn, reqn; bit bad;
        set_line(IDX_A, 1'b1, tag_of(ADR_A), 32'h40);
        do_snoop(T_WRITE, ADR_A, 0, r, d, lat, invn, reqn, bad);
        checks++; if (r !== R_POS) begin errors++; $display("FAIL wr_hit_resp: got %b want %b", r, R_POS); end
        checks++; if (invn !== 1) begin errors++; $display("FAIL wr_hit_inv_count: got %0d want 1", invn); end
        checks++; if (last_inv_idx !== IDX_A) begin errors++; $display("FAIL wr_hit_inv_idx: got %h want %h", last_inv_idx, IDX_A); end
        ref_valid[IDX_A] = 1'b0;
        bus.snoop_type_i = T_IDLE;
        tick();
        do_snoop(T_READ, ADR_A, 0, r, d, lat, invn, reqn, bad);
        checks++; if (r !== exp_resp(T_READ, ADR_A)) begin errors++; $display("FAIL wr_hit_reread: got %b want %b", r, exp_resp(T_READ, ADR_A)); end
        bus.snoop_type_i = T_IDLE;
        tick();
    endtask

    task automatic test_starvation();
        logic [1:0] r; logic [31:0] d; int lat, invn, reqn; bit bad;
        set_line(IDX_A, 1'b1, tag_of(ADR_A), 32'h40);
        do_snoop(T_READ, ADR_A, 5, r, d, lat, invn, reqn, bad);
        checks++; if (lat !== 8) begin errors++; $display("FAIL starve_latency: got %0d want 8", lat); end
        checks++; if (reqn !== 6) begin errors++; $display("FAIL starve_req_cycles: got %0d want 6", reqn); end
        checks++; if (bad) begin errors++; $display("FAIL starve_idx: got unstable tag_idx want %h", IDX_A); end
        checks++; if (r !== R_POS || d !== 32'h40) begin errors++; $display("FAIL starve_resp: got %b/%h want 11/40", r, d); end
        bus.snoop_type_i = T_IDLE;
        tick();
        do_snoop(T_NU, 32'h1234_5678, 0, r, d, lat, invn, reqn, bad);
        checks++; if (r !== R_NEG || lat !== 1) begin errors++; $display("FAIL not_used_resp: got %b after %0d want 00 after 1", r, lat); end
        tick();
        checks++; if (reqn !== 0 || bus.tag_req_o !== 1'b0) begin errors++; $display("FAIL not_used_req: got %0d req cycles want 0", reqn); end
        bus.snoop_type_i = T_IDLE;
        tick();
    endtask

    task automatic test_abort();
        logic [1:0] r; logic [31:0] d; int lat, invn, reqn, inv0; bit bad;
        set_line(IDX_A, 1'b1, tag_of(ADR_A), 32'h40);
        inv0 = inv_pulses;
        bus.snoop_adr_i = ADR_A; bus.snoop_type_i = T_WRITE; bus.tag_gnt_i = 1'b0;
        tick();
        checks++; if (bus.tag_req_o !== 1'b1) begin errors++; $display("FAIL abort_req_pre: got %b want 1", bus.tag_req_o); end
        bus.snoop_type_i = T_IDLE;
        #1;
        checks++; if (bus.tag_req_o !== 1'b0) begin errors++; $display("FAIL abort_req_drop: got %b want 0", bus.tag_req_o); end
        tick();
        bus.tag_gnt_i = 1'b1;
        tick();
        checks++; if (bus.snoop_response_o !== R_UND || bus.tag_req_o !== 1'b0) begin errors++; $display("FAIL abort_req_idle: got %b/%b want 10/0", bus.snoop_response_o, bus.tag_req_o); end
        bus.snoop_type_i = T_WRITE;
        tick();
        tick();
        checks++; if (bus.inv_o !== 1'b1) begin errors++; $display("FAIL abort_lookup_pre: got inv %b want 1", bus.inv_o); end
        bus.snoop_type_i = T_IDLE;
        #1;
        checks++; if (bus.inv_o !== 1'b0) begin errors++; $display("FAIL abort_lookup_inv: got %b want 0", bus.inv_o); end
        tick();
        checks++; if (bus.snoop_response_o !== R_UND) begin errors++; $display("FAIL abort_lookup_resp: got %b want 10", bus.snoop_response_o); end
        checks++; if (inv_pulses - inv0 !== 0) begin errors++; $display("FAIL abort_inv_count: got %0d want 0", inv_pulses - inv0); end
        do_snoop(T_READ, ADR_A, 0, r, d, lat, invn, reqn, bad);
        checks++; if (r !== R_POS || d !== 32'h40) begin errors++; $display("FAIL abort_line_kept: got %b/%h want 11/40", r, d); end
        bus.snoop_type_i = T_IDLE;
        tick();
    endtask

    task automatic test_async_reset();
        logic [1:0] r; logic [31:0] d; int lat, invn, reqn, inv0; bit bad;
        set_line(IDX_A, 1'b1, tag_of(ADR_A), 32'h40);
        do_snoop(T_READ, ADR_A, 0, r, d, lat, invn, reqn, bad);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.snoop_response_o !== R_UND || bus.snooped_dat_o !== 32'h0) begin errors++; $display("FAIL async_rst_resp: got %b/%h want 10/0", bus.snoop_response_o, bus.snooped_dat_o); end
        bus.snoop_type_i = T_IDLE;
        tick();
        rst = 1'b0;
        tick();
        inv0 = inv_pulses;
        bus.snoop_type_i = T_WRITE; bus.tag_gnt_i = 1'b1;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.inv_o !== 1'b0 || bus.tag_req_o !== 1'b0) begin errors++; $display("FAIL async_rst_inv: got inv %b req %b want 0/0", bus.inv_o, bus.tag_req_o); end
        bus.snoop_type_i = T_IDLE;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (ram_valid[IDX_A] !== 1'b1 || inv_pulses != inv0) begin errors++; $display("FAIL async_rst_line: got valid %b inv %0d want 1/0", ram_valid[IDX_A], inv_pulses - inv0); end
    endtask

    task automatic test_random();
        logic [1:0] r, typ, er; logic [31:0] d, a, ed, rnd; int lat, invn, reqn, deny, el; bit bad;
        for (int n = 0; n < 60; n++) begin
            rnd = $urandom;
            a = $urandom;
            if (rnd[0]) a[31:10] = ref_tag[idx_of(a)];
            typ = (rnd[4:1] == 4'h0) ? T_NU : (rnd[5] ? T_WRITE : T_READ);
            deny = $urandom_range(0, 3);
            er = exp_resp(typ, a);
            ed = exp_dat(typ, a);
            el = (typ == T_NU) ? 1 : 3 + deny;
            do_snoop(typ, a, deny, r, d, lat, invn, reqn, bad);
            checks++; if (r !== er || d !== ed) begin errors++; $display("FAIL rand_resp[%0d]: got %b/%h want %b/%h", n, r, d, er, ed); end
            checks++; if (lat !== el) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, el); end
            checks++; if (invn !== ((typ == T_WRITE && er == R_POS) ? 1 : 0)) begin errors++; $display("FAIL rand_inv[%0d]: got %0d pulses for type %b resp %b", n, invn, typ, er); end
            if (typ == T_WRITE && er == R_POS) ref_valid[idx_of(a)] = 1'b0;
            bus.snoop_type_i = T_IDLE;
            tick();
            checks++; if (bus.snoop_response_o !== R_UND || bus.snooped_dat_o !== 32'h0) begin errors++; $display("FAIL rand_release[%0d]: got %b/%h want 10/0", n, bus.snoop_response_o, bus.snooped_dat_o); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r0, r1;
        bus.snoop_type_i = T_IDLE;
        bus.snoop_adr_i  = '0;
        bus.tag_gnt_i    = 1'b0;
        bus.tag_i        = '0;
        bus.valid_i      = 1'b0;
        bus.dat_i        = '0;
        for (int i = 0; i < 256; i++) begin
            r0 = $urandom;
            r1 = $urandom;
            set_line(8'(i), r0[31] | r0[30], r0[TW-1:0], r1);
        end
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write_hit();
        test_starvation();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
